// File: rtl/mult_result_buffer_if.sv
// Handshake bundle between a multiplier producer, the result buffer and its consumer.
// Latency: none, wires only.
// Backpressure: in_ready flows back to the producer and out_ready flows in from the consumer.
interface mult_result_buffer_if;
    // Producer side: one multiplier product per accepted beat
    logic        in_valid;
    logic [20:0] in_result;
    logic        in_ready;

    // Consumer side: head-of-queue word, first-word fall-through
    logic        out_valid;
    logic [20:0] out_result;
    logic        out_ready;

    // Drives products in and takes results out (producer/consumer side)
    modport master (
        output in_valid,
        output in_result,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result
    );

    // The buffer itself
    modport slave (
        input  in_valid,
        input  in_result,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result
    );
endinterface

// File: rtl/mult_result_buffer.sv
// FWFT FIFO for multiplier products that sanitises special values and counts zero/inf/NaN.
// Latency: a push into an empty buffer shows on out_valid/out_result in the next cycle.
// Backpressure: in_ready = not full (independent of out_ready); the head is held until out_ready.
module mult_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_stats,
    mult_result_buffer_if.slave      bus,
    output logic [7:0]               zero_count,
    output logic [7:0]               inf_count,
    output logic [7:0]               nan_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Flag field of a product word: [20] inf, [19] zero; both set encodes a NaN error
    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    logic [20:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_zero_cnt;
    logic [7:0]    r_inf_cnt;
    logic [7:0]    r_nan_cnt;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_cls;
    logic [20:0]   w_san;

    // Saturating +1 so a stuck source cannot wrap a counter back to small values
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Handshake decode; in_ready looks only at occupancy so a full buffer never
    // takes a word even if the consumer drains one in the same cycle
    always_comb begin
        w_in_ready  = (r_level != LW'(DEPTH));
        w_out_valid = (r_level != '0);
        w_push      = bus.in_valid && w_in_ready;
        w_pop       = w_out_valid && bus.out_ready;
    end

    // Special values carry no payload: keep the flags, zero sign/exponent/fraction
    always_comb begin
        w_cls = bus.in_result[20:19];
        w_san = bus.in_result;
        if (w_cls != CLS_NONE) begin
            w_san = {w_cls, 19'd0};
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = r_mem[r_rd_ptr];

    assign level      = r_level;
    assign zero_count = r_zero_cnt;
    assign inf_count  = r_inf_cnt;
    assign nan_count  = r_nan_cnt;

    // Storage write; entries are cleared on reset so out_result reads 0 until the first push
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_san;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); level tracks net push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Classification counters; clear_stats beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            r_zero_cnt <= '0;
            r_inf_cnt  <= '0;
            r_nan_cnt  <= '0;
        end else if (w_push) begin
            case (w_cls)
                CLS_NAN:  r_nan_cnt  <= sat_inc(r_nan_cnt);
                CLS_INF:  r_inf_cnt  <= sat_inc(r_inf_cnt);
                CLS_ZERO: r_zero_cnt <= sat_inc(r_zero_cnt);
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_result_buffer.sv
// Bench for mult_result_buffer: queue-based reference model, per-cycle compare, directed + random stimulus.
// Latency: model and DUT both update on the rising edge; outputs compared on the falling edge.
// Backpressure: producer/consumer handshakes driven randomly and in directed full/empty scenarios.
module tb_mult_result_buffer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_stats = 1'b0;
    logic [7:0]    zero_count;
    logic [7:0]    inf_count;
    logic [7:0]    nan_count;
    logic [LW-1:0] level;

    mult_result_buffer_if bus();

    mult_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear_stats (clear_stats),
        .bus         (bus.slave),
        .zero_count  (zero_count),
        .inf_count   (inf_count),
        .nan_count   (nan_count),
        .level       (level)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [20:0] mq[$];
    int          m_zero = 0;
    int          m_inf  = 0;
    int          m_nan  = 0;
    bit          m_fresh = 1'b1;
    bit          started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] san(input logic [20:0] w);
        return (w[20:19] != 2'b00) ? {w[20:19], 19'd0} : w;
    endfunction

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Reference model: a plain queue with full/empty rules and saturating counters
    always @(posedge clk) begin : model
        bit p;
        bit o;
        started = 1'b1;
        if (reset) begin
            mq.delete();
            m_zero = 0; m_inf = 0; m_nan = 0;
            m_fresh = 1'b1;
        end else begin
            p = bus.in_valid && (mq.size() != DEPTH);
            o = bus.out_ready && (mq.size() != 0);
            if (o) void'(mq.pop_front());
            if (p) begin
                mq.push_back(san(bus.in_result));
                m_fresh = 1'b0;
            end
            if (clear_stats) begin
                m_zero = 0; m_inf = 0; m_nan = 0;
            end else if (p) begin
                case (bus.in_result[20:19])
                    2'b11:   m_nan  = sat(m_nan);
                    2'b10:   m_inf  = sat(m_inf);
                    2'b01:   m_zero = sat(m_zero);
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            chk("level",     32'(level),         32'(mq.size()));
            chk("in_ready",  32'(bus.in_ready),  32'(mq.size() != DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("zero_count", 32'(zero_count), 32'(m_zero));
            chk("inf_count",  32'(inf_count),  32'(m_inf));
            chk("nan_count",  32'(nan_count),  32'(m_nan));
            if (mq.size() != 0)
                chk("out_result", 32'(bus.out_result), 32'(mq[0]));
            else if (m_fresh)
                chk("out_result_after_reset", 32'(bus.out_result), 32'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [20:0] pushed[$];
    logic [20:0] got[$];
    logic [20:0] w;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        chk("rst_level", 32'(level), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_result", 32'(bus.out_result), 0);

        // In-order test
        bus.in_valid = 1'b1;
        bus.in_result = 21'h040000; cyc();
        chk("first_word_latency", 32'(bus.out_result), 32'h040000);
        bus.in_result = 21'h03C000; cyc();
        bus.in_result = 21'h012345; cyc();
        bus.in_valid = 1'b0;
        chk("order_level3", 32'(level), 3);
        chk("order_model_level3", 32'(mq.size()), 3);
        chk("order_head0", 32'(bus.out_result), 32'h040000);
        bus.out_ready = 1'b1;
        cyc(); chk("order_head1", 32'(bus.out_result), 32'h03C000);
        cyc(); chk("order_head2", 32'(bus.out_result), 32'h012345);
        cyc(); chk("order_empty", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // Full test
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_result = 21'($urandom) & 21'h07FFFF;
            cyc();
        end
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_level", 32'(level), 4);
        bus.in_result = 21'h011111; cyc();
        chk("full_refused_level", 32'(level), 4);
        chk("full_model_level", 32'(mq.size()), 4);
        // push + pop while full: push refused, level drops
        bus.out_ready = 1'b1; cyc();
        chk("full_pushpop_level", 32'(level), 3);
        chk("full_pushpop_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        bus.out_ready = 1'b0;
        chk("full_drained", 32'(level), 0);

        // Sanitise / classify test
        clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_result = 21'h1FFFFF; cyc();
        bus.in_result = 21'h0BFFFF; cyc();
        bus.in_valid = 1'b0;
        chk("san_head0", 32'(bus.out_result), 32'h180000);
        chk("san_nan", 32'(nan_count), 1);
        chk("san_zero", 32'(zero_count), 1);
        chk("san_model_nan", 32'(m_nan), 1);
        bus.out_ready = 1'b1; cyc();
        chk("san_head1", 32'(bus.out_result), 32'h080000);
        cyc();
        bus.out_ready = 1'b0;

        // Saturation test
        clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
        bus.in_valid = 1'b1; bus.in_result = 21'h100000; bus.out_ready = 1'b1;
        repeat (300) cyc();
        chk("sat_inf", 32'(inf_count), 32'hFF);
        chk("sat_model_inf", 32'(m_inf), 255);
        clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
        chk("sat_clear_beats_push", 32'(inf_count), 0);
        bus.in_valid = 1'b0; cyc();
        bus.out_ready = 1'b0;
        chk("sat_drained", 32'(level), 0);

        // Wrap test
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = 21'($urandom) & 21'h07FFFF;
            pushed.push_back(w);
            bus.in_result = w; cyc();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = 21'($urandom) & 21'h07FFFF;
            pushed.push_back(w);
            bus.in_result = w;
            got.push_back(bus.out_result);
            cyc();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("wrap_level", 32'(level), 2);
        for (int i = 0; i < 20; i++)
            chk("wrap_seq", 32'(got[i]), 32'(pushed[i]));
        bus.out_ready = 1'b1; cyc(); cyc(); bus.out_ready = 1'b0;

        // Reset test
        bus.in_valid = 1'b1;
        bus.in_result = 21'h100000; cyc();
        bus.in_result = 21'h080000; cyc();
        bus.in_result = 21'h180000; cyc();
        chk("rst_pre_level", 32'(level), 3);
        bus.in_result = 21'h012345;
        reset = 1'b1; cyc(); reset = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_mid_level", 32'(level), 0);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_out_result", 32'(bus.out_result), 0);
        chk("rst_mid_counters", 32'({zero_count, inf_count, nan_count}), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_result = 21'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            clear_stats   = ($urandom_range(0, 63) == 0);
            reset         = ($urandom_range(0, 255) == 0);
            cyc();
        end
        reset = 1'b0; clear_stats = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_result_buffer.md
MULT_RESULT_BUFFER -- requirements
Module: mult_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_result carries a multiplier product this cycle.
REQ-005 SHALL have port in_result, input, 21 bits: product word, laid out as [20] inf flag, [19] zero flag, [18] sign, [17:13] exponent, [12:0] fraction.
REQ-006 SHALL have port in_ready, output, 1 bit: the buffer accepts a word this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: out_result holds the head entry.
REQ-008 SHALL have port out_result, output, 21 bits: the head entry, in the same layout as in_result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the head entry this cycle.
REQ-010 SHALL have port clear_stats, input, 1 bit: synchronously zeroes the three statistics counters.
REQ-011 SHALL have ports zero_count, inf_count and nan_count, each output, 8 bits: saturating classification counters.
REQ-012 SHALL have port level, output, clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-013 SHALL accept a push when in_valid and in_ready are both 1 on a rising edge.
REQ-014 SHALL complete a pop when out_valid and out_ready are both 1 on a rising edge.
REQ-015 SHALL drive in_ready = (level != DEPTH) combinationally, with no dependence on out_ready; a full buffer refuses a push even when a pop happens in the same cycle.
REQ-016 SHALL drive out_valid = (level != 0) and present the head entry on out_result with zero added latency (first-word fall-through).
REQ-017 SHALL show a word pushed into an empty buffer on out_valid/out_result in the cycle after the push edge; minimum latency is 1 cycle.
REQ-018 SHALL, on a simultaneous push and pop with 0 < level < DEPTH, leave level unchanged and keep FIFO order.
REQ-019 SHALL update level by +1 on a push only, -1 on a pop only, and 0 on both or neither; level never leaves the range 0..DEPTH.
REQ-020 SHALL use read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-021 SHALL sanitise each word on push: if in_result[20:19] != 2'b00, store bits [18:0] as zero and keep bits [20:19] as received; otherwise store the word unchanged.
REQ-022 SHALL classify each accepted push exactly once:
  - [20:19] = 2'b11 (NaN error): increment nan_count.
  - [20:19] = 2'b10: increment inf_count.
  - [20:19] = 2'b01: increment zero_count.
  - [20:19] = 2'b00: no counter changes.
REQ-023 SHALL saturate each counter at 8'hFF, with no wrap.
REQ-024 SHALL give clear_stats priority over a same-cycle increment: the counter reads 0 after that edge and the push is not counted.
REQ-025 SHALL keep ignored inputs from changing state: in_result while no push occurs, and out_ready while out_valid = 0.

Reset
REQ-026 SHALL, on any rising edge with reset = 1, set level, both pointers and all counters to 0, giving out_valid = 0 and in_ready = 1.
REQ-027 SHALL keep out_result at 21'h0 from reset until the first push; storage entries SHALL be cleared to 0 by reset.
REQ-028 SHALL give reset priority over push, pop and clear_stats in the same cycle; a reset mid-stream discards all buffered entries.

Verification
REQ-029 SHALL pass the in-order test: push 21'h040000, 21'h03C000 and 21'h012345 with out_ready = 0; then level = 3 and out_result = 21'h040000; with out_ready = 1 the words pop out in the same order over 3 cycles.
REQ-030 SHALL pass the full test: with DEPTH = 4, five back-to-back pushes with out_ready = 0; the 5th is refused (in_ready = 0), level = 4; one pop then raises in_ready in the next cycle.
REQ-031 SHALL pass the sanitise/classify test: push 21'h1FFFFF then 21'h0BFFFF; the stored words are 21'h180000 and 21'h080000, with nan_count = 1 and zero_count = 1.
REQ-032 SHALL pass the saturation test: 300 pushes of 21'h100000 with pops enabled give inf_count = 8'hFF; clear_stats together with a push of 21'h100000 gives inf_count = 0.
REQ-033 SHALL pass the wrap test: at level = 2, 20 cycles of simultaneous push and pop keep level = 2 and the output sequence equals the input sequence delayed by 2 entries.
REQ-034 SHALL pass the reset test: reset asserted at level = 3 during a push gives level = 0, out_valid = 0, out_result = 0 and counters = 0 on the next cycle.
